// File: rtl/qsfp_rd_capture_pkg.sv
// Shared types and constants for the QSFP read-capture block: FSM states
// and the QSFP page to shadow-memory page-slot mapping.
package qsfp_rd_capture_pkg;

   localparam int NUM_PAGES      = 5;
   localparam int WORDS_PER_PAGE = 32;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_DATA,
      DONE,
      ACK_LOW
   } state_t;

   typedef struct packed {
      logic       valid;
      logic [2:0] idx;
   } page_map_t;

   // Pages 0x00, 0x02, 0x03, 0x20 and 0x21 are shadowed; every other page is unmapped.
   function automatic page_map_t page_to_idx(input logic [7:0] page);
      page_map_t m;
      m = '{valid: 1'b1, idx: 3'd0};
      case (page)
         8'h00:   m.idx = 3'd0;
         8'h02:   m.idx = 3'd1;
         8'h03:   m.idx = 3'd2;
         8'h20:   m.idx = 3'd3;
         8'h21:   m.idx = 3'd4;
         default: m     = '{valid: 1'b0, idx: 3'd0};
      endcase
      return m;
   endfunction

endpackage

// File: rtl/qsfp_rd_capture_if.sv
// Poller, I2C RX stream, shadow-memory write and status signals of the
// capture block. The slave modport is the capture block's view.
interface qsfp_rd_capture_if #(
   parameter int MEM_AW = 8,
   parameter int CNT_W  = 16
);
   logic [7:0]        src_data;
   logic              src_valid;
   logic              src_ready;
   logic              wren_logic;
   logic [7:0]        curr_rd_page;
   logic [7:0]        curr_rd_addr;
   logic              rd_done;
   logic              rd_done_ack;
   logic              wr_cnt_rst;
   logic              mem_wr_en;
   logic [MEM_AW-1:0] mem_wr_addr;
   logic [63:0]       mem_wr_data;
   logic [7:0]        mem_byteen;
   logic [CNT_W-1:0]  byte_cnt;
   logic [CNT_W-1:0]  drop_cnt;
   logic              timeout_err;
   logic              page_err;

   modport master (
      output src_data, src_valid, wren_logic, curr_rd_page, curr_rd_addr,
             rd_done_ack, wr_cnt_rst,
      input  src_ready, rd_done, mem_wr_en, mem_wr_addr, mem_wr_data, mem_byteen,
             byte_cnt, drop_cnt, timeout_err, page_err
   );

   modport slave (
      input  src_data, src_valid, wren_logic, curr_rd_page, curr_rd_addr,
             rd_done_ack, wr_cnt_rst,
      output src_ready, rd_done, mem_wr_en, mem_wr_addr, mem_wr_data, mem_byteen,
             byte_cnt, drop_cnt, timeout_err, page_err
   );

endinterface

// File: rtl/qsfp_rd_capture.sv
// Captures poller-requested I2C read bytes into the QSFP shadow memory and
// returns the per-byte rd_done/rd_done_ack handshake, with timeout and page checks.
module qsfp_rd_capture
   import qsfp_rd_capture_pkg::*;
#(
   parameter int MEM_AW         = 8,
   parameter int TIMEOUT_CYCLES = 100000,
   parameter int CNT_W          = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   qsfp_rd_capture_if.slave  bus
);

   localparam int               TMO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
   localparam bit               TMO_EN   = (TIMEOUT_CYCLES > 0);

   state_t              r_state;
   logic                r_src_ready;
   logic                r_rd_done;
   logic                r_mem_wr_en;
   logic [MEM_AW-1:0]   r_mem_wr_addr;
   logic [63:0]         r_mem_wr_data;
   logic [7:0]          r_mem_byteen;
   logic [TMO_W-1:0]    r_tmo_cnt;
   logic [CNT_W-1:0]    r_byte_cnt;
   logic [CNT_W-1:0]    r_drop_cnt;
   logic                r_timeout_err;
   logic                r_page_err;

   page_map_t w_map;
   logic      w_accept;
   logic      w_drop;
   logic      w_write;
   logic      w_page_miss;
   logic      w_tmo_hit;
   logic      w_tmo_fire;

   assign w_map       = page_to_idx(bus.curr_rd_page);
   assign w_accept    = bus.src_valid & r_src_ready;
   assign w_drop      = (r_state == IDLE) & w_accept;
   assign w_write     = (r_state == WAIT_DATA) & w_accept & w_map.valid;
   assign w_page_miss = (r_state == WAIT_DATA) & w_accept & ~w_map.valid;
   assign w_tmo_hit   = TMO_EN && (r_tmo_cnt == TMO_LAST);
   // A falling wren_logic abandons the byte silently, so it outranks the timeout.
   assign w_tmo_fire  = (r_state == WAIT_DATA) & ~w_accept & bus.wren_logic & w_tmo_hit;

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values of the others regardless of order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= IDLE;
         r_src_ready   <= 1'b0;
         r_rd_done     <= 1'b0;
         r_mem_wr_en   <= 1'b0;
         r_mem_wr_addr <= '0;
         r_mem_wr_data <= '0;
         r_mem_byteen  <= '0;
         r_tmo_cnt     <= '0;
      end else begin
         r_mem_wr_en <= 1'b0;
         case (r_state)
            IDLE: begin
               r_src_ready <= 1'b1;
               if (bus.wren_logic) begin
                  r_state   <= WAIT_DATA;
                  r_tmo_cnt <= '0;
               end
            end
            WAIT_DATA: begin
               if (w_accept) begin
                  r_state     <= DONE;
                  r_src_ready <= 1'b0;
                  r_rd_done   <= 1'b1;
                  if (w_map.valid) begin
                     r_mem_wr_en   <= 1'b1;
                     r_mem_wr_addr <= MEM_AW'({w_map.idx, bus.curr_rd_addr[7:3]});
                     r_mem_wr_data <= {8{bus.src_data}};
                     r_mem_byteen  <= 8'h01 << bus.curr_rd_addr[2:0];
                  end
               end else if (!bus.wren_logic) begin
                  r_state <= IDLE;
               end else if (w_tmo_hit) begin
                  r_state     <= DONE;
                  r_src_ready <= 1'b0;
                  r_rd_done   <= 1'b1;
               end else begin
                  r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
               end
            end
            DONE: begin
               if (bus.rd_done_ack) begin
                  r_state   <= ACK_LOW;
                  r_rd_done <= 1'b0;
               end
            end
            ACK_LOW: begin
               // Waiting for the ack to drop lets the poller advance curr_rd_addr first.
               if (!bus.rd_done_ack) begin
                  r_src_ready <= 1'b1;
                  r_tmo_cnt   <= '0;
                  r_state     <= bus.wren_logic ? WAIT_DATA : IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_byte_cnt    <= '0;
         r_drop_cnt    <= '0;
         r_timeout_err <= 1'b0;
         r_page_err    <= 1'b0;
      end else if (bus.wr_cnt_rst) begin
         r_byte_cnt    <= '0;
         r_drop_cnt    <= '0;
         r_timeout_err <= 1'b0;
         r_page_err    <= 1'b0;
      end else begin
         if (w_write && (r_byte_cnt != '1)) r_byte_cnt <= r_byte_cnt + CNT_W'(1);
         if (w_drop && (r_drop_cnt != '1))  r_drop_cnt <= r_drop_cnt + CNT_W'(1);
         if (w_page_miss)                   r_page_err    <= 1'b1;
         if (w_tmo_fire)                    r_timeout_err <= 1'b1;
      end
   end

   assign bus.src_ready   = r_src_ready;
   assign bus.rd_done     = r_rd_done;
   assign bus.mem_wr_en   = r_mem_wr_en;
   assign bus.mem_wr_addr = r_mem_wr_addr;
   assign bus.mem_wr_data = r_mem_wr_data;
   assign bus.mem_byteen  = r_mem_byteen;
   assign bus.byte_cnt    = r_byte_cnt;
   assign bus.drop_cnt    = r_drop_cnt;
   assign bus.timeout_err = r_timeout_err;
   assign bus.page_err    = r_page_err;

endmodule

// File: tb/tb_qsfp_rd_capture.sv
// Scoreboard bench for qsfp_rd_capture: a poller-style driver pushes expected
// shadow-memory writes, an independent monitor pops and compares them.
`timescale 1ns/1ps
module tb_qsfp_rd_capture;

   localparam int MEM_AW = 8;
   localparam int CNT_W  = 16;
   localparam int TMO    = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   qsfp_rd_capture_if #(.MEM_AW(MEM_AW), .CNT_W(CNT_W)) bus ();

   qsfp_rd_capture #(
      .MEM_AW        (MEM_AW),
      .TIMEOUT_CYCLES(TMO),
      .CNT_W         (CNT_W)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   typedef struct {
      logic [MEM_AW-1:0] addr;
      logic [63:0]       data;
      logic [7:0]        be;
   } wr_t;

   wr_t exp_q[$];
   int  m_byte, m_drop;
   bit  m_tmo, m_page;
   int  n_tests, n_fail;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference page map: slot number of a shadowed page, -1 when unmapped.
   function automatic int page_slot(input logic [7:0] p);
      logic [7:0] shadowed [5];
      shadowed = '{8'h00, 8'h02, 8'h03, 8'h20, 8'h21};
      for (int i = 0; i < 5; i++) if (shadowed[i] == p) return i;
      return -1;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_status(input string tag);
      check({tag, "_byte_cnt"},    bus.byte_cnt,    m_byte);
      check({tag, "_drop_cnt"},    bus.drop_cnt,    m_drop);
      check({tag, "_timeout_err"}, bus.timeout_err, m_tmo);
      check({tag, "_page_err"},    bus.page_err,    m_page);
   endtask

   task automatic model_clear();
      m_byte = 0;
      m_drop = 0;
      m_tmo  = 1'b0;
      m_page = 1'b0;
   endtask

   always @(negedge clk) begin
      wr_t e;
      if (rst_n && bus.mem_wr_en) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write", bus.mem_wr_addr, bus.mem_wr_data);
         end else begin
            e = exp_q.pop_front();
            check("wr_addr", bus.mem_wr_addr, e.addr);
            check("wr_data", bus.mem_wr_data, e.data);
            check("wr_byteen", bus.mem_byteen, e.be);
            check("rd_done_with_wr", bus.rd_done, 1);
         end
      end
   end

   // Called in the slot where the condition that moves the DUT into WAIT_DATA
   // on the next edge was just driven. Returns with rd_done_ack still high.
   task automatic do_byte(input logic [7:0] page, input logic [7:0] addr, input logic [7:0] data,
                          input int vdelay, input int adelay, input bit tmo);
      int  k;
      int  slot;
      wr_t e;
      bus.curr_rd_page = page;
      bus.curr_rd_addr = addr;
      if (tmo) begin
         k = 0;
         while (bus.rd_done !== 1'b1 && k < 64) begin
            step();
            k++;
         end
         check("timeout_latency", k, TMO + 1);
         m_tmo = 1'b1;
      end else begin
         slot = page_slot(page);
         if (slot < 0) begin
            m_page = 1'b1;
         end else begin
            e.addr = MEM_AW'(slot * 32 + addr / 8);
            e.data = {8{data}};
            e.be   = 8'(1 << (addr % 8));
            exp_q.push_back(e);
            m_byte++;
         end
         repeat (vdelay + 1) step();
         bus.src_data  = data;
         bus.src_valid = 1'b1;
         k = 0;
         @(negedge clk);
         while (bus.src_ready !== 1'b1 && k < 64) begin
            @(negedge clk);
            k++;
         end
         check("accept_in_time", k < 64, 1);
         step();
         bus.src_valid = 1'b0;
         check("rd_done_rise", bus.rd_done, 1);
      end
      repeat (adelay) step();
      check("rd_done_hold", bus.rd_done, 1);
      bus.rd_done_ack = 1'b1;
      step();
      check("rd_done_fall", bus.rd_done, 0);
   endtask

   task automatic end_burst();
      bus.rd_done_ack = 1'b0;
      bus.wren_logic  = 1'b0;
      step();
      step();
   endtask

   initial begin
      logic [7:0] rpages [8];
      rpages = '{8'h00, 8'h02, 8'h03, 8'h20, 8'h21, 8'h07, 8'hFF, 8'h01};
      n_tests = 0;
      n_fail  = 0;
      model_clear();
      bus.src_data     = '0;
      bus.src_valid    = 1'b0;
      bus.wren_logic   = 1'b0;
      bus.curr_rd_page = '0;
      bus.curr_rd_addr = '0;
      bus.rd_done_ack  = 1'b0;
      bus.wr_cnt_rst   = 1'b0;

      // Reset state
      repeat (3) step();
      check("rst_src_ready", bus.src_ready, 0);
      check("rst_rd_done", bus.rd_done, 0);
      check("rst_mem_wr_en", bus.mem_wr_en, 0);
      check_status("rst");
      rst_n = 1'b1;
      step();

      // Single byte, page 0x02 addr 0x85, ack three cycles after rd_done
      bus.wren_logic = 1'b1;
      do_byte(8'h02, 8'h85, 8'hA5, 0, 3, 1'b0);
      end_burst();
      check_status("single");

      // Unmapped page, then counter/flag clear
      bus.wren_logic = 1'b1;
      do_byte(8'h07, 8'h10, 8'h5A, 1, 0, 1'b0);
      end_burst();
      check_status("page_miss");
      bus.wr_cnt_rst = 1'b1;
      step();
      bus.wr_cnt_rst = 1'b0;
      model_clear();
      check_status("cnt_clear");

      // Timeout with no RX byte
      bus.wren_logic = 1'b1;
      do_byte(8'h00, 8'h00, 8'h00, 0, 1, 1'b1);
      end_burst();
      check_status("timeout");

      // Page 0x21 sweep over addresses 128..255
      bus.wren_logic = 1'b1;
      for (int a = 128; a < 256; a++) begin
         do_byte(8'h21, 8'(a), 8'($urandom), $urandom_range(0, 3), $urandom_range(0, 2), 1'b0);
         bus.rd_done_ack = 1'b0;
      end
      end_burst();
      check_status("sweep");

      // Randomised bursts mixing mapped, unmapped and timed-out bytes
      for (int b = 0; b < 6; b++) begin
         int n;
         n = $urandom_range(1, 20);
         bus.wren_logic = 1'b1;
         for (int i = 0; i < n; i++) begin
            do_byte(rpages[$urandom_range(0, 7)], 8'($urandom), 8'($urandom),
                    $urandom_range(0, 10), $urandom_range(0, 5), ($urandom_range(0, 9) == 0));
            if (i != n - 1) bus.rd_done_ack = 1'b0;
         end
         end_burst();
      end
      check_status("random");

      // Bytes arriving while the poller is not capturing are dropped
      bus.src_data  = 8'h11;
      bus.src_valid = 1'b1;
      repeat (3) step();
      bus.src_valid = 1'b0;
      m_drop += 3;
      check("drop_no_rd_done", bus.rd_done, 0);
      step();
      check_status("drop");

      // Clear coinciding with a drop increment
      bus.src_valid  = 1'b1;
      bus.wr_cnt_rst = 1'b1;
      step();
      bus.src_valid  = 1'b0;
      bus.wr_cnt_rst = 1'b0;
      model_clear();
      check_status("clear_wins");

      // Reset asserted while rd_done is pending, then resume with the next byte
      begin
         wr_t e;
         bus.curr_rd_page = 8'h00;
         bus.curr_rd_addr = 8'h09;
         bus.src_data     = 8'h3C;
         e.addr = MEM_AW'(0 * 32 + 8'h09 / 8);
         e.data = {8{8'h3C}};
         e.be   = 8'(1 << (8'h09 % 8));
         exp_q.push_back(e);
         m_byte++;
         bus.wren_logic = 1'b1;
         step();
         bus.src_valid = 1'b1;
         step();
         step();
         bus.src_valid = 1'b0;
         check("pre_rst_rd_done", bus.rd_done, 1);
         @(negedge clk);
         #1;
         rst_n = 1'b0;
         #1;
         model_clear();
         check("async_rst_rd_done", bus.rd_done, 0);
         check("async_rst_mem_wr_en", bus.mem_wr_en, 0);
         check("async_rst_src_ready", bus.src_ready, 0);
         check_status("async_rst");
         step();
         rst_n = 1'b1;
         do_byte(8'h03, 8'h42, 8'hC3, 2, 1, 1'b0);
         end_burst();
         check_status("resume");
      end

      repeat (3) step();
      check("writes_outstanding", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
      $fatal(1, "watchdog expired");
   end

endmodule
